// File: rtl/ex_alu_rs_if.sv
// Dispatch, CDB snoop and issue bundle between the rename/dispatch stage, the
// integer ALU reservation station and the ALU execute stage.
interface ex_alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 4
);
  // Dispatch side
  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_alu_type;
  logic [TAG_W-1:0]  disp_rob_tag;
  logic              disp_src1_rdy;
  logic [DATA_W-1:0] disp_src1;
  logic [TAG_W-1:0]  disp_src1_tag;
  logic              disp_src2_rdy;
  logic [DATA_W-1:0] disp_src2;
  logic [TAG_W-1:0]  disp_src2_tag;

  // Common data bus broadcast
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  // Issue side
  logic              iss_valid;
  logic              iss_ready;
  logic [OP_W-1:0]   iss_alu_type;
  logic [DATA_W-1:0] iss_src1;
  logic [DATA_W-1:0] iss_src2;
  logic [TAG_W-1:0]  iss_rob_tag;

  modport master (
    output disp_valid, disp_alu_type, disp_rob_tag,
    output disp_src1_rdy, disp_src1, disp_src1_tag,
    output disp_src2_rdy, disp_src2, disp_src2_tag,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    output iss_ready,
    input  iss_valid, iss_alu_type, iss_src1, iss_src2, iss_rob_tag
  );

  modport slave (
    input  disp_valid, disp_alu_type, disp_rob_tag,
    input  disp_src1_rdy, disp_src1, disp_src1_tag,
    input  disp_src2_rdy, disp_src2, disp_src2_tag,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    input  iss_ready,
    output iss_valid, iss_alu_type, iss_src1, iss_src2, iss_rob_tag
  );
endinterface

// File: rtl/ex_alu_rs.sv
// Integer ALU reservation station: collapsing queue (slot 0 oldest) that snoops
// the CDB for pending operands and issues the oldest fully-ready entry.
module ex_alu_rs #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TAG_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  ex_alu_rs_if.slave   bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  tag;
  } src_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  alu_type;
    logic [TAG_W-1:0] rob_tag;
    src_t             src1;
    src_t             src2;
  } slot_t;

  // Capture a broadcast into an operand still waiting on that producer tag.
  function automatic src_t snoop(input src_t s, input logic cdb_v,
                                 input logic [TAG_W-1:0] cdb_t,
                                 input logic [DATA_W-1:0] cdb_d);
    src_t r;
    r = s;
    if (!s.rdy && cdb_v && (s.tag == cdb_t)) begin
      r.rdy = 1'b1;
      r.val = cdb_d;
    end
    return r;
  endfunction

  slot_t            slot_q [ENTRIES];
  slot_t            slot_d [ENTRIES];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  slot_t            woken     [ENTRIES];
  slot_t            shifted   [ENTRIES];
  slot_t            collapsed [ENTRIES];
  slot_t            new_entry;
  src_t             new_src1;
  src_t             new_src2;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_ready;
  logic             disp_fire;
  logic             iss_fire;
  logic [CNT_W-1:0] cnt_after;

  assign disp_ready     = (count_q != CNT_W'(ENTRIES));
  assign bus.disp_ready = disp_ready;

  // Oldest ready entry wins; scanning from the top lets the lowest index overwrite.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (slot_q[i].valid && slot_q[i].src1.rdy && slot_q[i].src2.rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    bus.iss_valid    = sel_found;
    bus.iss_alu_type = '0;
    bus.iss_src1     = '0;
    bus.iss_src2     = '0;
    bus.iss_rob_tag  = '0;
    if (sel_found) begin
      bus.iss_alu_type = slot_q[sel_idx].alu_type;
      bus.iss_src1     = slot_q[sel_idx].src1.val;
      bus.iss_src2     = slot_q[sel_idx].src2.val;
      bus.iss_rob_tag  = slot_q[sel_idx].rob_tag;
    end
  end

  assign iss_fire  = sel_found & bus.iss_ready & ~flush;
  assign disp_fire = bus.disp_valid & disp_ready & ~flush;
  assign cnt_after = count_q - CNT_W'(iss_fire);

  // Incoming entry, with same-cycle CDB bypass for operands not yet ready.
  always_comb begin
    new_src1.rdy = bus.disp_src1_rdy;
    new_src1.val = bus.disp_src1_rdy ? bus.disp_src1 : '0;
    new_src1.tag = bus.disp_src1_tag;
    new_src2.rdy = bus.disp_src2_rdy;
    new_src2.val = bus.disp_src2_rdy ? bus.disp_src2 : '0;
    new_src2.tag = bus.disp_src2_tag;

    new_entry.valid    = 1'b1;
    new_entry.alu_type = bus.disp_alu_type;
    new_entry.rob_tag  = bus.disp_rob_tag;
    new_entry.src1     = snoop(new_src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    new_entry.src2     = snoop(new_src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Wakeup is applied before the collapse so a captured value moves with its entry.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      woken[i] = slot_q[i];
      if (slot_q[i].valid) begin
        woken[i].src1 = snoop(slot_q[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        woken[i].src2 = snoop(slot_q[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES - 1; i++) begin
      shifted[i] = woken[i + 1];
    end
    shifted[ENTRIES-1] = '0;
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      collapsed[i] = (iss_fire && (i >= int'(sel_idx))) ? shifted[i] : woken[i];
    end
  end

  // Collapse first, then append at the first free slot; flush overrides everything.
  always_comb begin
    count_d = cnt_after + CNT_W'(disp_fire);
    for (int i = 0; i < ENTRIES; i++) begin
      slot_d[i] = collapsed[i];
      if (disp_fire && (cnt_after == CNT_W'(i))) begin
        slot_d[i] = new_entry;
      end
    end
    if (flush) begin
      count_d = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        slot_d[i] = '0;
      end
    end
  end

  // NOTE: the slot array is reset whole, payload included, so no stale data
  // from before reset can later reappear on the issue port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge state.
      count_q <= count_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_rs.sv
// Directed self-checking bench for ex_alu_rs: dispatch, bypass, wakeup,
// oldest-ready selection, collapse, full/backpressure, flush and async reset.
module tb_ex_alu_rs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ex_alu_rs_if #(.DATA_W(32), .OP_W(4), .TAG_W(4)) bus ();

  ex_alu_rs #(.ENTRIES(4), .DATA_W(32), .OP_W(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid    = 1'b0;
    bus.disp_alu_type = '0;
    bus.disp_rob_tag  = '0;
    bus.disp_src1_rdy = 1'b0;
    bus.disp_src1     = '0;
    bus.disp_src1_tag = '0;
    bus.disp_src2_rdy = 1'b0;
    bus.disp_src2     = '0;
    bus.disp_src2_tag = '0;
    bus.cdb_valid     = 1'b0;
    bus.cdb_tag       = '0;
    bus.cdb_data      = '0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                      input logic s1r, input logic [31:0] s1, input logic [3:0] s1t,
                      input logic s2r, input logic [31:0] s2, input logic [3:0] s2t);
    bus.disp_valid    = 1'b1;
    bus.disp_alu_type = op;
    bus.disp_rob_tag  = rob;
    bus.disp_src1_rdy = s1r;
    bus.disp_src1     = s1;
    bus.disp_src1_tag = s1t;
    bus.disp_src2_rdy = s2r;
    bus.disp_src2     = s2;
    bus.disp_src2_tag = s2t;
  endtask

  task automatic cdb(input logic v, input logic [3:0] t, input logic [31:0] d);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  initial begin
    idle();
    bus.iss_ready = 1'b0;

    // Reset state, before any clock edge
    #2;
    check("rst_disp_ready", bus.disp_ready, 1);
    check("rst_iss_valid", bus.iss_valid, 0);
    check("rst_iss_src1", bus.iss_src1, 0);
    check("rst_iss_rob_tag", bus.iss_rob_tag, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Both operands ready: issues the cycle after dispatch
    disp(4'h1, 4'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    bus.iss_ready = 1'b1;
    tick();
    idle();
    check("add_iss_valid", bus.iss_valid, 1);
    check("add_iss_src1", bus.iss_src1, 5);
    check("add_iss_src2", bus.iss_src2, 7);
    check("add_iss_rob_tag", bus.iss_rob_tag, 1);
    check("add_iss_alu_type", bus.iss_alu_type, 4'h1);
    tick();
    check("add_drained_valid", bus.iss_valid, 0);
    check("add_drained_ready", bus.disp_ready, 1);
    check("add_drained_src1", bus.iss_src1, 0);

    // src2 waits on tag 3; unrelated broadcast first, then the producer
    disp(4'h2, 4'd2, 1'b1, 32'd11, 4'd0, 1'b0, 32'd0, 4'd3);
    tick();
    idle();
    check("wake_pending", bus.iss_valid, 0);
    cdb(1'b1, 4'd5, 32'h55);
    tick();
    idle();
    check("wake_foreign_tag", bus.iss_valid, 0);
    cdb(1'b1, 4'd3, 32'hDEADBEEF);
    tick();
    idle();
    check("wake_iss_valid", bus.iss_valid, 1);
    check("wake_iss_src2", bus.iss_src2, 32'hDEADBEEF);
    check("wake_iss_src1", bus.iss_src1, 11);
    check("wake_iss_rob_tag", bus.iss_rob_tag, 2);
    tick();
    check("wake_drained", bus.iss_valid, 0);

    // Dispatch-cycle CDB bypass
    disp(4'h3, 4'd4, 1'b0, 32'd0, 4'd6, 1'b1, 32'd20, 4'd0);
    cdb(1'b1, 4'd6, 32'd9);
    tick();
    idle();
    check("byp_iss_valid", bus.iss_valid, 1);
    check("byp_iss_src1", bus.iss_src1, 9);
    check("byp_iss_src2", bus.iss_src2, 20);
    tick();
    check("byp_drained", bus.iss_valid, 0);

    // Fill with backpressure, then drain oldest-first with a held dispatch
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'h4, 4'(i), 1'b1, 32'(100 + i), 4'd0, 1'b1, 32'(i), 4'd0);
      tick();
      check("fill_disp_ready", bus.disp_ready, (i < 3) ? 1 : 0);
    end
    check("full_iss_rob_tag", bus.iss_rob_tag, 0);
    check("full_iss_src1", bus.iss_src1, 100);
    disp(4'h5, 4'd9, 1'b1, 32'h99, 4'd0, 1'b1, 32'h9, 4'd0);
    bus.iss_ready = 1'b1;
    tick();
    check("drain0_next_tag", bus.iss_rob_tag, 1);
    check("drain0_disp_ready", bus.disp_ready, 1);
    tick();
    idle();
    check("drain1_next_tag", bus.iss_rob_tag, 2);
    check("drain1_disp_ready", bus.disp_ready, 1);
    tick();
    check("drain2_next_tag", bus.iss_rob_tag, 3);
    tick();
    check("drain3_next_tag", bus.iss_rob_tag, 9);
    check("drain3_src1", bus.iss_src1, 32'h99);
    tick();
    check("drain_empty_valid", bus.iss_valid, 0);
    check("drain_empty_ready", bus.disp_ready, 1);

    // Older pending, younger ready; wakeup during a shift; older re-selected
    bus.iss_ready = 1'b0;
    disp(4'h6, 4'd5, 1'b0, 32'd0, 4'd7, 1'b0, 32'd0, 4'd7);
    tick();
    disp(4'h7, 4'd6, 1'b1, 32'h66, 4'd0, 1'b1, 32'h6, 4'd0);
    tick();
    disp(4'h8, 4'd8, 1'b0, 32'd0, 4'd12, 1'b1, 32'h18, 4'd0);
    tick();
    disp(4'h9, 4'd10, 1'b1, 32'hAA, 4'd0, 1'b1, 32'hA, 4'd0);
    tick();
    idle();
    check("ooo_full", bus.disp_ready, 0);
    check("ooo_younger_sel", bus.iss_rob_tag, 6);
    bus.iss_ready = 1'b1;
    cdb(1'b1, 4'd12, 32'hC0DE);
    tick();
    idle();
    bus.iss_ready = 1'b0;
    check("shift_wake_tag", bus.iss_rob_tag, 8);
    check("shift_wake_src1", bus.iss_src1, 32'hC0DE);
    check("shift_wake_src2", bus.iss_src2, 32'h18);
    cdb(1'b1, 4'd7, 32'h77);
    tick();
    idle();
    check("older_wake_tag", bus.iss_rob_tag, 5);
    check("older_wake_src1", bus.iss_src1, 32'h77);
    check("older_wake_src2", bus.iss_src2, 32'h77);
    bus.iss_ready = 1'b1;
    tick();
    check("ooo_drain_a", bus.iss_rob_tag, 8);
    tick();
    check("ooo_drain_c", bus.iss_rob_tag, 10);
    tick();
    check("ooo_empty", bus.iss_valid, 0);

    // Flush of a full station overrides dispatch, issue and wakeup
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'hA, 4'(i), 1'b1, 32'(200 + i), 4'd0, 1'b1, 32'd1, 4'd0);
      tick();
    end
    check("pre_flush_full", bus.disp_ready, 0);
    flush = 1'b1;
    disp(4'hB, 4'd11, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    cdb(1'b1, 4'd1, 32'h1234);
    bus.iss_ready = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_iss_valid", bus.iss_valid, 0);
    check("flush_disp_ready", bus.disp_ready, 1);
    check("flush_rob_tag", bus.iss_rob_tag, 0);
    tick();
    check("flush_no_dispatch", bus.iss_valid, 0);

    // Asynchronous reset mid-stream, between clock edges
    bus.iss_ready = 1'b0;
    disp(4'hC, 4'd12, 1'b1, 32'h123, 4'd0, 1'b1, 32'h456, 4'd0);
    tick();
    idle();
    check("pre_rst_valid", bus.iss_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", bus.iss_valid, 0);
    check("async_rst_ready", bus.disp_ready, 1);
    check("async_rst_src1", bus.iss_src1, 0);
    check("async_rst_rob_tag", bus.iss_rob_tag, 0);
    rst = 1'b0;
    tick();
    check("post_rst_empty", bus.iss_valid, 0);
    disp(4'hD, 4'd13, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    bus.iss_ready = 1'b1;
    tick();
    idle();
    check("post_rst_issue", bus.iss_rob_tag, 13);
    tick();
    check("post_rst_drained", bus.iss_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_alu_rs.md
Name: ex_alu_rs

Overview:
- Reservation station for the integer ALU; sits directly upstream of the ALU execute stage.
- Accepts dispatched ALU ops whose operands may still be pending.
- Captures pending operands by snooping the common data bus (CDB).
- Issues the oldest fully-ready entry to the ALU: alu_type, src1, src2, plus the ROB tag that travels with the result.

Parameters:
ENTRIES, 4, number of station slots (power of two, >=2)
DATA_W, 32, operand width, equals the common datapath width
OP_W, 4, alu_type encoding width, equals the ALU type width
TAG_W, 4, ROB tag width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  station can accept this cycle
disp_alu_type  in  OP_W  operation code
disp_rob_tag  in  TAG_W  destination ROB tag
disp_src1_rdy  in  1  src1 value valid
disp_src1  in  DATA_W  src1 value (ignored if not ready)
disp_src1_tag  in  TAG_W  src1 producer tag (used if not ready)
disp_src2_rdy  in  1  src2 value valid
disp_src2  in  DATA_W  src2 value
disp_src2_tag  in  TAG_W  src2 producer tag
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcasting ROB tag
cdb_data  in  DATA_W  broadcast value
iss_valid  out  1  issue candidate present
iss_ready  in  1  ALU/CDB slot accepts issue
iss_alu_type  out  OP_W  to ALU alu_type
iss_src1  out  DATA_W  to ALU src1
iss_src2  out  DATA_W  to ALU src2
iss_rob_tag  out  TAG_W  tag accompanying result

Behaviour:
- Storage is a collapsing queue. Slot 0 is oldest.
- Per slot: valid, alu_type, rob_tag, and for each operand a rdy bit, value and tag.
- count register holds 0..ENTRIES occupied slots, contiguous from slot 0.
- disp_ready = (count != ENTRIES), derived from registered count only. No same-cycle reuse of a slot being issued.
- Dispatch fires on disp_valid & disp_ready. The new entry is written into the lowest free slot after any collapse.
- Dispatch bypass: if an operand is not ready and cdb_valid & cdb_tag==disp_srcN_tag in the same cycle, store cdb_data with rdy=1.
- Wakeup: each cycle, every valid slot with srcN rdy=0 and matching cdb_valid/cdb_tag captures cdb_data and sets rdy=1, effective next cycle. src1 and src2 may both wake on the same broadcast.
- Issue select is combinational from registered state.
  - The lowest-index valid slot with both rdy=1 is selected.
  - iss_valid=1 with its fields driven.
  - If no slot qualifies: iss_valid=0 and all iss_* data outputs are 0.
- Issue fires on iss_valid & iss_ready. The selected slot is removed at the edge; all higher slots shift down one; count decrements.
- Simultaneous dispatch and issue: collapse first, then append. count is unchanged.
- Simultaneous wakeup and shift: the captured value follows the entry to its new slot.
- iss_valid is independent of iss_ready (no combinational path from iss_ready to iss_valid). Fields hold while iss_ready=0, unless an older entry becomes ready, which re-selects.
- Latency:
  - Dispatch with both operands ready at edge N: iss_valid at cycle N+1.
  - CDB wakeup at cycle N: issue possible at N+1.
- flush: at the next edge, all valid bits and count are cleared. Flush overrides a coincident dispatch, issue and wakeup. No issue fire is counted in the flush cycle.
- rst (asynchronous): all valid bits, rdy bits and count go to 0 immediately.
  - Outputs during/after reset: disp_ready=1, iss_valid=0, iss_alu_type/iss_src1/iss_src2/iss_rob_tag=0.
  - Reset mid-operation discards all entries.
- Tag matching ignores slots with valid=0. A broadcast of a tag not held in the station has no effect.

Test Plan:
- Dispatch ADD, src1=5, src2=7, both ready, iss_ready=1 -> next cycle iss_valid=1, iss_src1=5, iss_src2=7, tag echoed; following cycle count=0.
- Dispatch op with src2 waiting on tag 3; broadcast cdb_tag=3, cdb_data=0xDEADBEEF two cycles later -> iss_valid rises the cycle after broadcast, iss_src2=0xDEADBEEF.
- Dispatch with src1 pending tag 6 while cdb_valid, cdb_tag=6, cdb_data=9 in the same cycle -> entry captured ready, issues next cycle with iss_src1=9.
- Fill 4 entries with iss_ready=0 -> disp_ready=0 after 4th. Then iss_ready=1 with a dispatch held -> slots issue oldest-first (tags 0,1,2,3); no overflow.
- Older entry pending, younger ready -> younger issues first. Older wakes -> becomes selected before further younger entries.
- Full station, assert flush with concurrent dispatch/iss_ready -> next cycle count=0, iss_valid=0, disp_ready=1. Async rst pulse mid-stream clears outputs without a clock edge.
